fixed_point_requantizer: RTL and testbench

Streaming, time-multiplexed requantizer that converts wide accumulator samples (IN format) to narrower output samples (OUT format) with selectable rounding, then saturation. It sits between the mixer MAC datapath and the output/bus formatting stages. Per-channel sticky clip flags and clip counters feed the control-plane meters.

---
 rtl/fixed_point_requantizer.sv | 171 +++++++++++++++++
 tb/tb_fixed_point_requantizer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_requantizer.sv
// Streaming requantizer: wide accumulator samples -> narrower output samples.
// Stage 1 rounds and drops fractional bits, stage 2 saturates to the output width.
// Per-channel sticky clip flags and saturating clip counters are maintained
// from the registered output stream.
module fixed_point_requantizer #(
   parameter int IN_WIDTH      = 36,
   parameter int IN_FRAC_BITS  = 30,
   parameter int OUT_WIDTH     = 24,
   parameter int OUT_FRAC_BITS = 20,
   parameter int NUM_CHANNELS  = 8,
   parameter int CHAN_WIDTH    = $clog2(NUM_CHANNELS),
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              round_mode,
   input  logic                    in_valid,
   input  logic [CHAN_WIDTH-1:0]   in_channel,
   input  logic [IN_WIDTH-1:0]     in_data,
   output logic                    out_valid,
   output logic [CHAN_WIDTH-1:0]   out_channel,
   output logic [OUT_WIDTH-1:0]    out_data,
   output logic                    out_saturated,
   output logic [NUM_CHANNELS-1:0] clip_flags,
   input  logic [NUM_CHANNELS-1:0] clip_clear,
   input  logic [CHAN_WIDTH-1:0]   count_sel,
   output logic [COUNT_WIDTH-1:0]  clip_count
);

   localparam int DROP = IN_FRAC_BITS - OUT_FRAC_BITS;
   // Width of the rounded value: one guard bit above the input keeps rounding from wrapping.
   localparam int RW   = IN_WIDTH + 1 - DROP;

   typedef enum logic [1:0] {
      RM_FLOOR   = 2'd0,
      RM_HALF_UP = 2'd1,
      RM_CONV    = 2'd2,
      RM_FLOOR3  = 2'd3
   } round_mode_e;

   if (DROP < 0) begin : g_bad_drop
      $error("fixed_point_requantizer: OUT_FRAC_BITS must not exceed IN_FRAC_BITS");
   end
   if ((IN_WIDTH - IN_FRAC_BITS) < (OUT_WIDTH - OUT_FRAC_BITS)) begin : g_bad_int
      $error("fixed_point_requantizer: IN integer bits must be >= OUT integer bits");
   end

   logic [IN_WIDTH:0]      ext;
   logic [RW-1:0]          rnd_d, rnd_q;
   logic                   vld1_q;
   logic [CHAN_WIDTH-1:0]  ch1_q;

   logic [OUT_WIDTH-1:0]   data_d, data_q;
   logic                   sat_d, sat_q;
   logic                   vld2_q;
   logic [CHAN_WIDTH-1:0]  ch2_q;

   logic [NUM_CHANNELS-1:0] flags_d, flags_q, hit;
   logic [COUNT_WIDTH-1:0]  cnt_d [NUM_CHANNELS];
   logic [COUNT_WIDTH-1:0]  cnt_q [NUM_CHANNELS];
   logic [COUNT_WIDTH-1:0]  count_q;

   assign ext = {in_data[IN_WIDTH-1], in_data};

   if (DROP == 0) begin : g_pass
      // No fractional bits dropped: every rounding mode is a pass-through.
      assign rnd_d = ext;
   end else begin : g_round
      localparam logic [IN_WIDTH:0] HALF = {{IN_WIDTH{1'b0}}, 1'b1} << (DROP - 1);
      logic [IN_WIDTH:0] inc;
      logic [IN_WIDTH:0] sum;
      logic              tie_even;

      // Stage 1 combinational: pick the rounding increment, add, drop fraction bits.
      always_comb begin
         tie_even = (in_data[DROP-1:0] == HALF[DROP-1:0]) && !in_data[DROP];
         inc      = '0;
         case (round_mode_e'(round_mode))
            RM_HALF_UP: inc = HALF;
            RM_CONV:    inc = tie_even ? '0 : HALF;
            default:    inc = '0;
         endcase
         sum   = ext + inc;
         rnd_d = sum[IN_WIDTH:DROP];
      end
   end

   // Stage 1 register: rounded value with its channel and valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld1_q <= 1'b0;
         ch1_q  <= '0;
         rnd_q  <= '0;
      end else begin
         vld1_q <= in_valid;
         ch1_q  <= in_channel;
         rnd_q  <= rnd_d;
      end
   end

   // Stage 2 combinational: value fits when all bits from OUT_WIDTH-1 upward agree.
   always_comb begin
      sat_d  = !((&rnd_q[RW-1:OUT_WIDTH-1]) || !(|rnd_q[RW-1:OUT_WIDTH-1]));
      data_d = rnd_q[OUT_WIDTH-1:0];
      if (sat_d) begin
         data_d = rnd_q[RW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                              : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   end

   // Stage 2 register: the output sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld2_q <= 1'b0;
         ch2_q  <= '0;
         data_q <= '0;
         sat_q  <= 1'b0;
      end else begin
         vld2_q <= vld1_q;
         ch2_q  <= ch1_q;
         data_q <= data_d;
         sat_q  <= vld1_q && sat_d;
      end
   end

   // Clip event decode per channel from the registered output.
   always_comb begin
      hit = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         hit[c] = vld2_q && sat_q && (ch2_q == CHAN_WIDTH'(c));
      end
   end

   // Clip flag/counter update; a clip coinciding with a clear still counts as one event.
   always_comb begin
      flags_d = flags_q;
      cnt_d   = cnt_q;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (clip_clear[c]) begin
            flags_d[c] = hit[c];
            cnt_d[c]   = hit[c] ? COUNT_WIDTH'(1) : '0;
         end else if (hit[c]) begin
            flags_d[c] = 1'b1;
            if (cnt_q[c] != '1) begin
               cnt_d[c] = cnt_q[c] + 1'b1;
            end
         end
      end
   end

   // Clip state registers and registered counter readout.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= '0;
         cnt_q   <= '{default: '0};
         count_q <= '0;
      end else begin
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         count_q <= cnt_q[count_sel];
      end
   end

   assign out_valid     = vld2_q;
   assign out_channel   = ch2_q;
   assign out_data      = data_q;
   assign out_saturated = sat_q;
   assign clip_flags    = flags_q;
   assign clip_count    = count_q;

endmodule

// File: tb/tb_fixed_point_requantizer.sv
// Directed bench for fixed_point_requantizer with default parameters (DROP=10),
// plus a second instance with a 2-bit clip counter for counter saturation.
module tb_fixed_point_requantizer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  round_mode;
   logic        in_valid;
   logic [2:0]  in_channel;
   logic [35:0] in_data;
   logic        out_valid;
   logic [2:0]  out_channel;
   logic [23:0] out_data;
   logic        out_saturated;
   logic [7:0]  clip_flags;
   logic [7:0]  clip_clear;
   logic [2:0]  count_sel;
   logic [15:0] clip_count;

   logic        in_valid_s;
   logic [2:0]  in_channel_s;
   logic [35:0] in_data_s;
   logic        out_valid_s;
   logic [2:0]  out_channel_s;
   logic [23:0] out_data_s;
   logic        out_saturated_s;
   logic [7:0]  clip_flags_s;
   logic [7:0]  clip_clear_s;
   logic [2:0]  count_sel_s;
   logic [1:0]  clip_count_s;

   fixed_point_requantizer u_dut (
      .clk(clk), .reset(reset), .round_mode(round_mode),
      .in_valid(in_valid), .in_channel(in_channel), .in_data(in_data),
      .out_valid(out_valid), .out_channel(out_channel), .out_data(out_data),
      .out_saturated(out_saturated), .clip_flags(clip_flags), .clip_clear(clip_clear),
      .count_sel(count_sel), .clip_count(clip_count)
   );

   fixed_point_requantizer #(.COUNT_WIDTH(2)) u_small (
      .clk(clk), .reset(reset), .round_mode(round_mode),
      .in_valid(in_valid_s), .in_channel(in_channel_s), .in_data(in_data_s),
      .out_valid(out_valid_s), .out_channel(out_channel_s), .out_data(out_data_s),
      .out_saturated(out_saturated_s), .clip_flags(clip_flags_s), .clip_clear(clip_clear_s),
      .count_sel(count_sel_s), .clip_count(clip_count_s)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one sample (called 1 time unit after a rising edge) and returns
   // out_valid one cycle later plus the full output two cycles later.
   task automatic send(input logic [2:0] ch, input logic [1:0] mode, input logic [35:0] d,
                       output logic v_mid, output logic v, output logic [2:0] och,
                       output logic [23:0] od, output logic os);
      in_valid   = 1'b1;
      in_channel = ch;
      round_mode = mode;
      in_data    = d;
      tick(1);
      in_valid = 1'b0;
      in_data  = '0;
      v_mid    = out_valid;
      tick(1);
      v   = out_valid;
      och = out_channel;
      od  = out_data;
      os  = out_saturated;
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [35:0] din;
      logic [23:0] exp_data;
      logic        exp_sat;
   } vec_t;

   vec_t vt[20];

   logic        vm, vv, vs;
   logic [2:0]  vc;
   logic [23:0] vd;

   logic        sv [9];
   logic [2:0]  sch[9];

   initial begin
      vt[0]  = '{2'd0, 36'h000000200, 24'h000000, 1'b0};
      vt[1]  = '{2'd1, 36'h000000200, 24'h000001, 1'b0};
      vt[2]  = '{2'd2, 36'h000000200, 24'h000000, 1'b0};
      vt[3]  = '{2'd2, 36'h000000600, 24'h000002, 1'b0};
      vt[4]  = '{2'd3, 36'h000000600, 24'h000001, 1'b0};
      vt[5]  = '{2'd0, 36'hFFFFFFE00, 24'hFFFFFF, 1'b0};
      vt[6]  = '{2'd1, 36'hFFFFFFE00, 24'h000000, 1'b0};
      vt[7]  = '{2'd2, 36'hFFFFFFE00, 24'h000000, 1'b0};
      vt[8]  = '{2'd2, 36'hFFFFFFA00, 24'hFFFFFE, 1'b0};
      vt[9]  = '{2'd1, 36'hFFFFFFA00, 24'hFFFFFF, 1'b0};
      vt[10] = '{2'd0, 36'h7FFFFFFFF, 24'h7FFFFF, 1'b1};
      vt[11] = '{2'd0, 36'h800000000, 24'h800000, 1'b1};
      vt[12] = '{2'd0, 36'h1FFFFFC00, 24'h7FFFFF, 1'b0};
      vt[13] = '{2'd1, 36'h1FFFFFE00, 24'h7FFFFF, 1'b1};
      vt[14] = '{2'd0, 36'h1FFFFFE00, 24'h7FFFFF, 1'b0};
      vt[15] = '{2'd2, 36'h000000A00, 24'h000002, 1'b0};
      vt[16] = '{2'd1, 36'h000000A00, 24'h000003, 1'b0};
      vt[17] = '{2'd2, 36'h000000A01, 24'h000003, 1'b0};
      vt[18] = '{2'd0, 36'hE00000000, 24'h800000, 1'b0};
      vt[19] = '{2'd0, 36'hDFFFFFC00, 24'h800000, 1'b1};

      reset        = 1'b1;
      round_mode   = 2'd0;
      in_valid     = 1'b1;
      in_channel   = 3'd1;
      in_data      = 36'h7FFFFFFFF;
      clip_clear   = '0;
      count_sel    = 3'd1;
      in_valid_s   = 1'b0;
      in_channel_s = '0;
      in_data_s    = '0;
      clip_clear_s = '0;
      count_sel_s  = '0;

      // Reset state, with a clipping input held during reset.
      tick(4);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_sat", 64'(out_saturated), 64'd0);
      check("rst_out_channel", 64'(out_channel), 64'd0);
      check("rst_clip_flags", 64'(clip_flags), 64'd0);
      check("rst_clip_count", 64'(clip_count), 64'd0);
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tick(2);
      check("idle_out_valid", 64'(out_valid), 64'd0);

      // Table-driven rounding / saturation vectors on channel 0.
      for (int i = 0; i < 20; i++) begin
         send(3'd0, vt[i].mode, vt[i].din, vm, vv, vc, vd, vs);
         check($sformatf("vec%0d_valid_early", i), 64'(vm), 64'd0);
         check($sformatf("vec%0d_valid", i), 64'(vv), 64'd1);
         check($sformatf("vec%0d_channel", i), 64'(vc), 64'd0);
         check($sformatf("vec%0d_data", i), 64'(vd), 64'(vt[i].exp_data));
         check($sformatf("vec%0d_sat", i), 64'(vs), 64'(vt[i].exp_sat));
      end
      count_sel = 3'd0;
      tick(3);
      check("ch0_flags_after_table", 64'(clip_flags), 64'h01);
      check("ch0_count_after_table", 64'(clip_count), 64'd4);

      clip_clear = '1;
      tick(1);
      clip_clear = '0;
      tick(2);
      check("flags_after_clear_all", 64'(clip_flags), 64'h00);
      check("count_after_clear_all", 64'(clip_count), 64'd0);

      // Three clips on channel 3.
      count_sel = 3'd3;
      for (int k = 0; k < 3; k++) begin
         send(3'd3, 2'd0, 36'h7FFFFFFFF, vm, vv, vc, vd, vs);
         check($sformatf("ch3_clip%0d_sat", k), 64'(vs), 64'd1);
      end
      tick(3);
      check("ch3_count_3", 64'(clip_count), 64'd3);
      check("ch3_flags_3", 64'(clip_flags), 64'h08);

      // Fourth clip coincident with clear: event survives.
      send(3'd3, 2'd0, 36'h800000000, vm, vv, vc, vd, vs);
      check("ch3_clip4_sat", 64'(vs), 64'd1);
      clip_clear = 8'h08;
      tick(1);
      clip_clear = '0;
      tick(2);
      check("coincident_flags", 64'(clip_flags), 64'h08);
      check("coincident_count", 64'(clip_count), 64'd1);

      // Clear alone.
      clip_clear = 8'h08;
      tick(1);
      clip_clear = '0;
      tick(2);
      check("clear_flags", 64'(clip_flags), 64'h00);
      check("clear_count", 64'(clip_count), 64'd0);

      // 2-bit counter saturates at 3 after five back-to-back clips.
      round_mode = 2'd0;
      for (int k = 0; k < 5; k++) begin
         in_valid_s   = 1'b1;
         in_channel_s = 3'd2;
         in_data_s    = 36'h7FFFFFFFF;
         tick(1);
      end
      in_valid_s  = 1'b0;
      count_sel_s = 3'd2;
      tick(6);
      check("small_count_hold", 64'(clip_count_s), 64'd3);
      check("small_flags", 64'(clip_flags_s), 64'h04);

      // Streaming ch0..ch7 with a bubble after ch3; expected data = channel + 1.
      for (int s = 0; s < 9; s++) begin
         sv[s]  = (s != 4);
         sch[s] = (s < 4) ? 3'(s) : 3'(s - 1);
      end
      round_mode = 2'd0;
      for (int s = 0; s < 11; s++) begin
         if (s < 2) begin
            check($sformatf("stream%0d_valid", s), 64'(out_valid), 64'd0);
         end else begin
            check($sformatf("stream%0d_valid", s), 64'(out_valid), 64'(sv[s-2]));
            if (sv[s-2]) begin
               check($sformatf("stream%0d_channel", s), 64'(out_channel), 64'(sch[s-2]));
               check($sformatf("stream%0d_data", s), 64'(out_data), 64'(sch[s-2]) + 64'd1);
            end
         end
         if (s < 9) begin
            in_valid   = sv[s];
            in_channel = sch[s];
            in_data    = (36'(sch[s]) + 36'd1) << 10;
         end else begin
            in_valid = 1'b0;
            in_data  = '0;
         end
         tick(1);
      end

      // Reset with two clipping samples in flight.
      send(3'd5, 2'd0, 36'h7FFFFFFFF, vm, vv, vc, vd, vs);
      tick(2);
      check("pre_reset_flags", 64'(clip_flags), 64'h20);
      in_valid   = 1'b1;
      in_channel = 3'd6;
      in_data    = 36'h7FFFFFFFF;
      tick(1);
      reset = 1'b1;
      tick(1);
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      count_sel = 3'd6;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("post_reset%0d_valid", k), 64'(out_valid), 64'd0);
         tick(1);
      end
      check("post_reset_flags", 64'(clip_flags), 64'h00);
      check("post_reset_count6", 64'(clip_count), 64'd0);
      count_sel = 3'd5;
      tick(2);
      check("post_reset_count5", 64'(clip_count), 64'd0);
      check("post_reset_small_flags", 64'(clip_flags_s), 64'h00);
      check("post_reset_small_count", 64'(clip_count_s), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
